// File: rtl/timer_irq_controller.sv
// ---------------------------------------------------------------------------
// timer_irq_controller
//
// Turns the level interrupt lines of the down-counting timer into pending
// bits. It picks one pending line at a time and offers it to the CPU through
// a req/ack/EOI handshake. After EOI it pulls the timer enable low for one
// cycle so the timer reloads and restarts.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   io_irqIn         level interrupt lines from the timer
//   io_irqMask       per-line enable (1 = line may raise a request)
//   io_globalEnable  0 blocks new requests, never aborts one in flight
//   io_irqAck        CPU accepts the current request (REQ only)
//   io_irqEoi        CPU ends interrupt service (SERVICE only)
//   io_irqReq        request to CPU
//   io_irqId         index of the requested / in-service line
//   io_inService     high while the CPU services the interrupt
//   io_pending       raw pending register, unmasked
//   io_timerEnable   timer enable; low for one cycle to force a reload
// ---------------------------------------------------------------------------
module timer_irq_controller #(
  parameter int unsigned NUM_IRQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  io_irqIn,
  input  logic [NUM_IRQ-1:0]  io_irqMask,
  input  logic                io_globalEnable,
  input  logic                io_irqAck,
  input  logic                io_irqEoi,
  output logic                io_irqReq,
  output logic [ID_WIDTH-1:0] io_irqId,
  output logic                io_inService,
  output logic [NUM_IRQ-1:0]  io_pending,
  output logic                io_timerEnable
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    RELOAD  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  prev_irq_q, prev_irq_d;
  logic [ID_WIDTH-1:0] id_q, id_d;

  // Output flops: next values are decoded from the next state so outputs
  // track the state register exactly, with no input-to-output path.
  logic                irq_req_q, irq_req_d;
  logic                in_service_q, in_service_d;
  logic                timer_enable_q, timer_enable_d;

  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  eligible;
  logic                win_any;
  logic [ID_WIDTH-1:0] win_id;

  // Rising-edge detect and arbitration candidates.
  always_comb begin
    rise     = io_irqIn & ~prev_irq_q;
    eligible = pending_q & io_irqMask;
  end

  // Fixed-priority encoder: lowest index wins, so scan from the top down.
  always_comb begin
    win_any = |eligible;
    win_id  = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_id = ID_WIDTH'(i);
      end
    end
  end

  // Next-state, pending and output decode.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    id_d       = id_q;
    prev_irq_d = io_irqIn;

    unique case (state_q)
      IDLE: begin
        if (io_globalEnable && win_any) begin
          state_d = REQ;
          id_d    = win_id;
        end
      end
      REQ: begin
        if (io_irqAck) begin
          state_d         = SERVICE;
          pending_d[id_q] = 1'b0;
        end
      end
      SERVICE: begin
        if (io_irqEoi) begin
          state_d = RELOAD;
        end
      end
      RELOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // New edges are applied after the ack clear so a coincident set wins.
    pending_d = pending_d | rise;

    irq_req_d      = (state_d == REQ);
    in_service_d   = (state_d == SERVICE);
    timer_enable_d = (state_d != RELOAD);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      prev_irq_q     <= '0;
      id_q           <= '0;
      irq_req_q      <= 1'b0;
      in_service_q   <= 1'b0;
      timer_enable_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      prev_irq_q     <= prev_irq_d;
      id_q           <= id_d;
      irq_req_q      <= irq_req_d;
      in_service_q   <= in_service_d;
      timer_enable_q <= timer_enable_d;
    end
  end

  assign io_irqReq      = irq_req_q;
  assign io_irqId       = id_q;
  assign io_inService   = in_service_q;
  assign io_pending     = pending_q;
  assign io_timerEnable = timer_enable_q;

endmodule

// File: tb/tb_timer_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_timer_irq_controller
//
// Directed walk through the handshake scenarios followed by random traffic.
// Every cycle the DUT outputs are compared with a transaction-level model
// (list of pending events, one handshake phase, the id being served).
// ---------------------------------------------------------------------------
module tb_timer_irq_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic [3:0] irq_mask;
  logic       global_en;
  logic       irq_ack;
  logic       irq_eoi;
  logic       irq_req;
  logic [1:0] irq_id;
  logic       in_service;
  logic [3:0] pending;
  logic       timer_en;

  int checks   = 0;
  int failures = 0;

  timer_irq_controller #(.NUM_IRQ(4), .ID_WIDTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .io_irqIn        (irq_in),
    .io_irqMask      (irq_mask),
    .io_globalEnable (global_en),
    .io_irqAck       (irq_ack),
    .io_irqEoi       (irq_eoi),
    .io_irqReq       (irq_req),
    .io_irqId        (irq_id),
    .io_inService    (in_service),
    .io_pending      (pending),
    .io_timerEnable  (timer_en)
  );

  always #5 clk = ~clk;

  // Reference model: the handshake is a phase name, pending is a bit list.
  string m_phase = "idle";
  bit    m_prev [4];
  bit    m_pend [4];
  int    m_id = 0;

  function automatic int lowest_set(input bit v [4]);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_edge();
    bit elig [4];
    bit rise [4];
    bit nxt  [4];
    int w;
    if (reset) begin
      m_phase = "idle";
      m_id    = 0;
      for (int i = 0; i < 4; i++) begin m_prev[i] = 0; m_pend[i] = 0; end
      return;
    end
    for (int i = 0; i < 4; i++) begin
      rise[i]   = irq_in[i] && !m_prev[i];
      m_prev[i] = irq_in[i];
      elig[i]   = m_pend[i] && irq_mask[i];
      nxt[i]    = m_pend[i];
    end
    if (m_phase == "idle") begin
      w = lowest_set(elig);
      if (global_en && w >= 0) begin m_phase = "req"; m_id = w; end
    end else if (m_phase == "req") begin
      if (irq_ack) begin m_phase = "service"; nxt[m_id] = 0; end
    end else if (m_phase == "service") begin
      if (irq_eoi) m_phase = "reload";
    end else begin
      m_phase = "idle";
    end
    for (int i = 0; i < 4; i++) m_pend[i] = nxt[i] || rise[i];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [3:0] ep;
    for (int i = 0; i < 4; i++) ep[i] = m_pend[i];
    check("req",        32'(irq_req),    32'(m_phase == "req"));
    check("in_service", 32'(in_service), 32'(m_phase == "service"));
    check("timer_en",   32'(timer_en),   32'(m_phase != "reload"));
    check("irq_id",     32'(irq_id),     32'(m_id));
    check("pending",    32'(pending),    32'(ep));
  endtask

  // One clock: model consumes the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; irq_mask = '0; global_en = 1'b0;
    irq_ack = 1'b0; irq_eoi = 1'b0;
    step(); step();
    check("rst_timer_en", 32'(timer_en), 32'd1);
    reset = 1'b0;

    // 1: single event on line 2
    irq_mask = 4'b1111; global_en = 1'b1; irq_in = 4'b0100;
    step();
    check("t1_pending", 32'(pending), 32'h4);
    step();
    check("t1_req", 32'(irq_req), 32'd1);
    check("t1_id",  32'(irq_id),  32'd2);
    step();
    irq_in = '0; irq_ack = 1'b1;
    step();
    check("t1_insvc",   32'(in_service), 32'd1);
    check("t1_pend_clr", 32'(pending),   32'h0);
    irq_ack = 1'b0; irq_eoi = 1'b1;
    step();
    check("t1_reload", 32'(timer_en), 32'd0);
    irq_eoi = 1'b0;
    step();
    check("t1_ten_back", 32'(timer_en), 32'd1);
    check("t1_idle_req", 32'(irq_req),  32'd0);

    // 2: priority between lines 3 and 1
    irq_in = 4'b1010;
    step(); step();
    check("t2_first_id", 32'(irq_id), 32'd1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
    step();
    check("t2_gap_req", 32'(irq_req), 32'd0);
    step();
    check("t2_second_req", 32'(irq_req), 32'd1);
    check("t2_second_id",  32'(irq_id),  32'd3);
    irq_in = '0;
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
    step(); step();

    // 3: masked line held high, then unmasked; no retrigger while held
    irq_mask = 4'b1110; irq_in = 4'b0001;
    for (int i = 0; i < 20; i++) step();
    check("t3_pending0", 32'(pending[0]), 32'd1);
    check("t3_no_req",   32'(irq_req),    32'd0);
    irq_mask = 4'b1111;
    step();
    check("t3_req_id0", 32'({irq_req, irq_id}), 32'h4);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("t3_no_retrigger", 32'(irq_req), 32'd0);
    irq_in = '0; step();

    // 4: rise on the served line in the ack cycle keeps it pending
    irq_in = 4'b0100; step();
    irq_in = 4'b0000; step();
    irq_in = 4'b0100; irq_ack = 1'b1; step();
    check("t4_svc",      32'(in_service), 32'd1);
    check("t4_pend_set", 32'(pending[2]), 32'd1);
    irq_in = '0; irq_ack = 1'b0;
    irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
    step(); step();
    check("t4_rereq", 32'({irq_req, irq_id}), 32'h6);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
    step(); step();

    // 5: ignored handshakes, global enable dropped during REQ
    irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
    check("t5_eoi_idle", 32'(timer_en), 32'd1);
    irq_in = 4'b0001; step(); irq_in = '0; step();
    irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
    check("t5_eoi_req", 32'(irq_req), 32'd1);
    global_en = 1'b0; step(); step();
    check("t5_ge_hold", 32'(irq_req), 32'd1);
    irq_ack = 1'b1; step(); step(); irq_ack = 1'b0;
    check("t5_ack_svc", 32'(in_service), 32'd1);
    global_en = 1'b1;
    irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
    step();

    // 6: reset while in service with line 3 pending and still high
    irq_in = 4'b1000; step(); step();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    irq_in = '0; step();
    irq_in = 4'b1000; step();
    check("t6_pre_pend", 32'(pending), 32'h8);
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_rst_outs", 32'({irq_req, irq_id, in_service, pending, timer_en}), 32'h001);
    step(); step();
    check("t6_retrigger", 32'({irq_req, irq_id}), 32'h7);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) irq_in[i] = ~irq_in[i];
      if ($urandom_range(0, 15) == 0) irq_mask = 4'($urandom);
      global_en = ($urandom_range(0, 7) != 0);
      irq_ack   = ($urandom_range(0, 2) == 0);
      irq_eoi   = ($urandom_range(0, 2) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
